// File: rtl/calc_pkg.sv
// Shared operator/error codes, FSM encoding and default width for calc_sequencer.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_DIV0 = 2'd2,
    ERR_INV  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// One-step-per-cycle magnitude datapath: unsigned shift-add multiply or restoring divide.
// hi holds the product high half / partial remainder, lo the multiplier / dividend-quotient.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_part_c;
  logic [WIDTH-1:0] div_diff_c;

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    mul_sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_part_c = {hi_q, lo_q[WIDTH-1]};
    // A successful trial difference is below the divisor, so W bits hold it exactly.
    div_diff_c = div_part_c[WIDTH-1:0] - m_q;
    if (load) begin
      hi_d = '0;
      lo_d = mag_a;
      m_d  = mag_b;
    end else if (step) begin
      if (div_mode) begin
        if (div_part_c >= {1'b0, m_q}) begin
          hi_d = div_diff_c;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_part_c[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum_c[WIDTH:1];
        lo_d = {mul_sum_c[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign prod = {hi_q, lo_q};
  assign quot = lo_q;
  assign rem  = hi_q;

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle signed add/sub/mul/div/mod controller with start/busy/done handshake.
// Optional CALC_SEQUENCER_CHAIN_EN adds a `chain` input that reuses the last answer as operand1.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operator,
`ifdef CALC_SEQUENCER_CHAIN_EN
  input  logic             chain,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [1:0]       err
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  err_e             err_pend_q, err_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic [1:0]       err_q, err_d;

  logic               iter_load_c;
  logic               iter_step_c;
  logic               div_mode_c;
  logic [WIDTH-1:0]   mag_a_c;
  logic [WIDTH-1:0]   mag_b_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c;
  logic [WIDTH-1:0]   rem_c;
  logic [WIDTH-1:0]   fix_ans_c;
  err_e               fix_err_c;

  always_comb begin
    mag_a_c    = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b_c    = b_q[WIDTH-1] ? -b_q : b_q;
    div_mode_c = (op_q == OP_DIV) || (op_q == OP_MOD);
  end

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (sw_clk),
    .rst      (rst),
    .load     (iter_load_c),
    .step     (iter_step_c),
    .div_mode (div_mode_c),
    .mag_a    (mag_a_c),
    .mag_b    (mag_b_c),
    .prod     (prod_c),
    .quot     (quot_c),
    .rem      (rem_c)
  );

  // Sign fix-up and overflow detection on the finished magnitudes.
  always_comb begin
    fix_ans_c = '0;
    fix_err_c = ERR_NONE;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fix_ans_c = sum_q[WIDTH-1:0];
        if (sum_q[WIDTH] != sum_q[WIDTH-1]) fix_err_c = ERR_OVF;
      end
      OP_MUL: begin
        fix_ans_c = qsign_q ? -prod_c[WIDTH-1:0] : prod_c[WIDTH-1:0];
        if (prod_c[2*WIDTH-1:WIDTH] != '0) begin
          fix_err_c = ERR_OVF;
        end else if (prod_c[WIDTH-1] && (!qsign_q || (prod_c[WIDTH-2:0] != '0))) begin
          fix_err_c = ERR_OVF;
        end
      end
      OP_DIV: begin
        fix_ans_c = qsign_q ? -quot_c : quot_c;
        if (!qsign_q && quot_c[WIDTH-1]) fix_err_c = ERR_OVF;
      end
      OP_MOD: begin
        fix_ans_c = rsign_q ? -rem_c : rem_c;
      end
      default: ;
    endcase
    if (err_pend_q != ERR_NONE) fix_err_c = err_pend_q;
    if (fix_err_c != ERR_NONE) fix_ans_c = '0;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    err_pend_d  = err_pend_q;
    cnt_d       = cnt_q;
    ans_d       = ans_q;
    err_d       = err_q;
    iter_load_c = 1'b0;
    iter_step_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef CALC_SEQUENCER_CHAIN_EN
          a_d = chain ? ans_q : operand1;
`else
          a_d = operand1;
`endif
          b_d        = operand2;
          op_d       = operator;
          err_pend_d = ERR_NONE;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        qsign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        rsign_d = a_q[WIDTH-1];
        case (op_q)
          OP_ADD: begin
            sum_d   = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
            state_d = S_FIX;
          end
          OP_SUB: begin
            sum_d   = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
            state_d = S_FIX;
          end
          OP_MUL: begin
            iter_load_c = 1'b1;
            state_d     = S_ITER;
          end
          OP_DIV, OP_MOD: begin
            if (b_q == '0) begin
              err_pend_d = ERR_DIV0;
              state_d    = S_FIX;
            end else begin
              iter_load_c = 1'b1;
              state_d     = S_ITER;
            end
          end
          default: begin
            err_pend_d = ERR_INV;
            state_d    = S_FIX;
          end
        endcase
      end
      S_ITER: begin
        iter_step_c = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        ans_d   = fix_ans_c;
        err_d   = fix_err_c;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SETUP) || (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      err_pend_q <= ERR_NONE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ans_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ans_q      <= ans_d;
      err_q      <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ans  = ans_q;
  assign err  = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed corner cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_calc_sequencer;

  localparam int unsigned W = 32;

  logic         sw_clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [2:0]   operator;
  logic         busy;
  logic         done;
  logic [W-1:0] ans;
  logic [1:0]   err;
`ifdef CALC_SEQUENCER_CHAIN_EN
  logic         chain = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 sw_clk = ~sw_clk;

  calc_sequencer #(.WIDTH(W)) dut (
    .sw_clk   (sw_clk),
    .rst      (rst),
    .start    (start),
    .operand1 (operand1),
    .operand2 (operand2),
    .operator (operator),
`ifdef CALC_SEQUENCER_CHAIN_EN
    .chain    (chain),
`endif
    .busy     (busy),
    .done     (done),
    .ans      (ans),
    .err      (err)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic in 64 bits, then range checks.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] m_ans, output logic [1:0] m_err);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    m_err = 2'd0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: if (sb == 0) m_err = 2'd2; else r = sa / sb;
      3'd4: if (sb == 0) m_err = 2'd2; else r = sa % sb;
      default: m_err = 2'd3;
    endcase
    if (m_err == 2'd0 && (r > 64'sd2147483647 || r < -64'sd2147483648)) m_err = 2'd1;
    m_ans = (m_err == 2'd0) ? W'(r) : '0;
  endtask

  function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] b);
    if (op == 3'd2) return 3 + W;
    if ((op == 3'd3 || op == 3'd4) && b != '0) return 3 + W;
    return 3;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'h7FFF_FFFF;
      3: v = '1;
      4: begin v = W'($urandom_range(0, 40)); v = v - 32'd20; end
      5: v = W'($urandom_range(0, 65535));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Issue one operation, then check latency, busy window, result and done pulse width.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] e_ans;
    logic [1:0]   e_err;
    int lat, busy_cycles;
    bit seen;
    model(op, a, b, e_ans, e_err);
    @(negedge sw_clk);
    operand1 = a;
    operand2 = b;
    operator = op;
    start    = 1'b1;
    @(posedge sw_clk);
    lat = 1;
    @(negedge sw_clk);
    start    = 1'b0;
    operand1 = $urandom();
    operand2 = $urandom();
    operator = 3'($urandom());
    seen = 1'b0;
    busy_cycles = 0;
    while (!seen && lat < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        @(posedge sw_clk);
        lat++;
        @(negedge sw_clk);
      end
    end
    check({tag, " latency"}, W'(lat), W'(exp_latency(op, b)));
    check({tag, " busy_cycles"}, W'(busy_cycles), W'(exp_latency(op, b) - 1));
    check({tag, " busy_at_done"}, W'(busy), '0);
    check({tag, " ans"}, ans, e_ans);
    check({tag, " err"}, W'(err), W'(e_err));
    @(posedge sw_clk);
    @(negedge sw_clk);
    check({tag, " done_single"}, W'(done), '0);
    check({tag, " ans_held"}, ans, e_ans);
  endtask

  initial begin
    logic [W-1:0] e_ans, got_ans;
    logic [1:0]   e_err;
    int ndone;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    start = 1'b0;
    operand1 = '0;
    operand2 = '0;
    operator = '0;
    repeat (3) @(posedge sw_clk);
    @(negedge sw_clk);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset ans", ans, '0);
    check("reset err", W'(err), '0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'd5, "add 7+5");
    run_op(3'd1, 32'd5, 32'd7, "sub 5-7");
    run_op(3'd2, -32'd6, 32'd7, "mul -6*7");
    run_op(3'd3, -32'd7, 32'd2, "div -7/2");
    run_op(3'd4, -32'd7, 32'd2, "mod -7%2");
    run_op(3'd3, 32'h8000_0000, '1, "div min/-1");
    run_op(3'd4, 32'h8000_0000, '1, "mod min%-1");
    run_op(3'd3, 32'd9, 32'd0, "div 9/0");
    run_op(3'd4, 32'd9, 32'd0, "mod 9/0");
    run_op(3'd6, 32'd1, 32'd2, "invalid op6");
    run_op(3'd0, 32'h7FFF_FFFF, 32'd1, "add max+1");
    run_op(3'd1, 32'h8000_0000, 32'd1, "sub min-1");
    run_op(3'd2, 32'd65536, 32'd65536, "mul 2^16*2^16");
    run_op(3'd2, 32'h8000_0000, 32'd1, "mul min*1");
    run_op(3'd2, 32'h8000_0000, '1, "mul min*-1");
    run_op(3'd3, 32'd100, -32'd7, "div 100/-7");

    // A second start during ITER must be dropped.
    model(3'd2, -32'd6, 32'd7, e_ans, e_err);
    @(negedge sw_clk);
    operand1 = -32'd6;
    operand2 = 32'd7;
    operator = 3'd2;
    start = 1'b1;
    ndone = 0;
    got_ans = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge sw_clk);
      @(negedge sw_clk);
      start = (i == 6);
      if (i == 6) begin
        operand1 = 32'd1;
        operand2 = 32'd1;
        operator = 3'd0;
      end
      if (done) begin
        ndone++;
        got_ans = ans;
      end
    end
    check("overlap done_count", W'(ndone), 32'd1);
    check("overlap ans", got_ans, e_ans);

    // Reset in ITER cycle 10 aborts without a done pulse.
    @(negedge sw_clk);
    operand1 = 32'd3;
    operand2 = 32'd3;
    operator = 3'd2;
    start = 1'b1;
    @(posedge sw_clk);
    @(negedge sw_clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge sw_clk);
      @(negedge sw_clk);
    end
    check("abort busy_before", W'(busy), 32'd1);
    rst = 1'b1;
    @(posedge sw_clk);
    @(negedge sw_clk);
    rst = 1'b0;
    check("abort busy", W'(busy), '0);
    check("abort done", W'(done), '0);
    check("abort ans", ans, '0);
    check("abort err", W'(err), '0);
    ndone = 0;
    repeat (40) begin
      @(posedge sw_clk);
      @(negedge sw_clk);
      if (done) ndone++;
    end
    check("abort no_done", W'(ndone), '0);
    run_op(3'd0, 32'd100, 32'd23, "post-reset add");

    // Held start: one operation per IDLE visit, four cycles apart.
    @(negedge sw_clk);
    operand1 = 32'd2;
    operand2 = 32'd3;
    operator = 3'd0;
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge sw_clk);
      @(negedge sw_clk);
      if (done) ndone++;
    end
    start = 1'b0;
    repeat (6) begin
      @(posedge sw_clk);
      @(negedge sw_clk);
      if (done) ndone++;
    end
    check("held_start done_count", W'(ndone), 32'd3);
    check("held_start ans", ans, 32'd5);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, $sformatf("rand%0d op%0d a=%0h b=%0h", k, rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
